commit_trace_tx: RTL and testbench

Hardware counterpart to the bench-side writeback monitor: it captures every retired register write from the Top_CPU write-back stage and serialises it off-chip as a framed byte stream on a UART TX line. Records are buffered in a small FIFO so bursts of back-to-back retirements do not stall the pipeline. The block sits beside `Top_CPU`, tapping the MEM/WB outputs, and its `tx` pin goes to the board UART bridge.

---
 rtl/commit_trace_pkg.sv | 35 +++
 rtl/uart_tx_byte.sv | 56 +++++
 rtl/commit_trace_tx.sv | 122 ++++++++++++
 tb/tb_commit_trace_tx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_trace_pkg.sv
// Shared constants, FSM state type and record byte selection for the
// commit trace serialiser.
package commit_trace_pkg;

  localparam logic [7:0] TRACE_HDR     = 8'hA5;
  localparam int         REC_W         = 69;
  localparam logic [3:0] BYTES_PER_REC = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_t;

  // Record layout is {pc[68:37], rd[36:32], data[31:0]}; byte 0 is the header.
  function automatic logic [7:0] rec_byte(input logic [REC_W-1:0] rec,
                                          input logic [3:0]       idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = TRACE_HDR;
      4'd1:    b = rec[68:61];
      4'd2:    b = rec[60:53];
      4'd3:    b = rec[52:45];
      4'd4:    b = rec[44:37];
      4'd5:    b = {3'b000, rec[36:32]};
      4'd6:    b = rec[31:24];
      4'd7:    b = rec[23:16];
      4'd8:    b = rec[15:8];
      4'd9:    b = rec[7:0];
      default: b = TRACE_HDR;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter, LSB first; done pulses in the last cycle of the stop
// bit so a back-to-back start continues with no idle gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] baud_reg;
  logic [3:0]    bit_reg;   // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]    shift_reg;
  logic          active_reg;
  logic          tx_reg;
  logic          bit_end;

  assign bit_end = active_reg && (baud_reg == '0);
  assign done    = bit_end && (bit_reg == 4'd9);
  assign tx      = tx_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_reg <= 1'b0;
      tx_reg     <= 1'b1;
      baud_reg   <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
    end else if (start && (!active_reg || done)) begin
      active_reg <= 1'b1;
      tx_reg     <= 1'b0;
      baud_reg   <= BAUD_RELOAD;
      bit_reg    <= '0;
      shift_reg  <= data;
    end else if (bit_end) begin
      if (bit_reg == 4'd9) begin
        active_reg <= 1'b0;
        tx_reg     <= 1'b1;
      end else begin
        bit_reg   <= bit_reg + 4'd1;
        baud_reg  <= BAUD_RELOAD;
        tx_reg    <= (bit_reg == 4'd8) ? 1'b1 : shift_reg[0];
        shift_reg <= shift_reg >> 1;
      end
    end else if (active_reg) begin
      baud_reg <= baud_reg - 1'b1;
    end
  end

endmodule

// File: rtl/commit_trace_tx.sv
// Captures retired register writes into a small FIFO and streams each one
// out over UART as a 10-byte frame.
module commit_trace_tx
  import commit_trace_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 8,
  parameter bit FILTER_X0    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_data,
  output logic        tx,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  drop_count
);

  localparam int AW = $clog2(DEPTH);

  logic [REC_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
  logic [REC_W-1:0] hold_reg;
  logic [3:0]       idx_reg, idx_next;
  state_t           state_reg, state_next;
  logic             overflow_reg;
  logic [7:0]       drop_reg;

  logic       empty, full, capture, push, pop, drop;
  logic       tx_start, tx_done;
  logic [7:0] tx_data;

  assign capture = wb_valid & wb_reg_write & ~(FILTER_X0 & (wb_rd == 5'd0));
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop     = (state_reg == LOAD);
  // A pop on the same edge frees a slot, so a push into a full FIFO survives.
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  assign busy       = (state_reg != IDLE) || !empty;
  assign overflow   = overflow_reg;
  assign drop_count = drop_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= {wb_pc, wb_rd, wb_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      state_reg    <= IDLE;
      idx_reg      <= '0;
      hold_reg     <= '0;
      overflow_reg <= 1'b0;
      drop_reg     <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) begin
        hold_reg   <= mem[rd_ptr_reg[AW-1:0]];
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_reg != 8'hFF) drop_reg <= drop_reg + 8'd1;
      end
    end
  end

  // The header is constant, so LOAD starts it while the record is still
  // being moved into hold_reg.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    tx_start   = 1'b0;
    tx_data    = TRACE_HDR;
    case (state_reg)
      IDLE: begin
        if (!empty) state_next = LOAD;
      end
      LOAD: begin
        state_next = SEND;
        idx_next   = '0;
        tx_start   = 1'b1;
      end
      SEND: begin
        if (tx_done) begin
          if (idx_reg < BYTES_PER_REC - 4'd1) begin
            idx_next = idx_reg + 4'd1;
            tx_start = 1'b1;
            tx_data  = rec_byte(hold_reg, idx_reg + 4'd1);
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk  (clk),
    .rst  (rst),
    .start(tx_start),
    .data (tx_data),
    .tx   (tx),
    .done (tx_done)
  );

endmodule

// File: tb/tb_commit_trace_tx.sv
// Directed bench for commit_trace_tx: decodes the UART line and compares
// frames, timing and drop accounting against hand-computed values.
module tb_commit_trace_tx;

  localparam int CPB = 4;
  localparam int DEP = 4;
  localparam int FRAME_CYC = 100 * CPB;
  localparam int FRAME_GAP = FRAME_CYC + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0, wb_reg_write = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_pc = '0, wb_data = '0;
  logic        tx0, busy0, ovf0, tx1, busy1, ovf1;
  logic [7:0]  dc0, dc1;
  logic        mon_sel = 1'b0;
  logic        mon_tx;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mon_tx = mon_sel ? tx1 : tx0;

  commit_trace_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEP), .FILTER_X0(1'b1)) dut0 (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd), .wb_pc(wb_pc), .wb_data(wb_data),
    .tx(tx0), .busy(busy0), .overflow(ovf0), .drop_count(dc0));

  commit_trace_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEP), .FILTER_X0(1'b0)) dut1 (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd), .wb_pc(wb_pc), .wb_data(wb_data),
    .tx(tx1), .busy(busy1), .overflow(ovf1), .drop_count(dc1));

  typedef struct {
    logic [7:0] b;
    int         c;
  } rx_t;
  rx_t rxq[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // UART receiver: samples each bit in its first cycle, aborts on reset.
  initial begin : rx_mon
    int sc;
    logic [7:0] bv;
    bit ab;
    forever begin
      @(negedge clk);
      if (!rst && mon_tx === 1'b0) begin
        sc = cyc;
        ab = 1'b0;
        bv = '0;
        for (int i = 0; i < 9; i++) begin
          for (int j = 0; j < CPB; j++) begin
            @(negedge clk);
            if (rst) ab = 1'b1;
          end
          if (ab) break;
          if (i < 8) bv[i] = mon_tx;
          else check("stop_bit", 32'(mon_tx), 32'd1);
        end
        if (!ab) rxq.push_back('{b: bv, c: sc});
      end
    end
  end

  function automatic logic [7:0] exp_byte(input logic [31:0] pc, input logic [4:0] rd,
                                          input logic [31:0] d, input int k);
    logic [7:0] r;
    case (k)
      0: r = 8'hA5;
      1: r = pc[31:24];
      2: r = pc[23:16];
      3: r = pc[15:8];
      4: r = pc[7:0];
      5: r = {3'b000, rd};
      6: r = d[31:24];
      7: r = d[23:16];
      8: r = d[15:8];
      default: r = d[7:0];
    endcase
    return r;
  endfunction

  task automatic check_frame(input string tag, input int first, input logic [31:0] pc,
                             input logic [4:0] rd, input logic [31:0] d, input int start);
    for (int k = 0; k < 10; k++) begin
      if (first + k < rxq.size()) begin
        check({tag, "_byte"}, 32'(rxq[first + k].b), 32'(exp_byte(pc, rd, d, k)));
        check({tag, "_start_cyc"}, rxq[first + k].c, start + 10 * CPB * k);
      end else begin
        check({tag, "_missing_byte"}, 32'(first + k), 32'(rxq.size()));
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] d);
    wb_valid = v; wb_reg_write = w; wb_rd = rd; wb_pc = pc; wb_data = d;
    @(posedge clk);
    #1;
    wb_valid = 1'b0; wb_reg_write = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wb_valid = 1'b0; wb_reg_write = 1'b0;
    tick(2);
    rst = 1'b0;
    rxq.delete();
  endtask

  typedef struct {
    logic        v;
    logic        w;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] d;
    logic        frame;
  } vec_t;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    vec_t vecs[6];
    int n;
    vecs[0] = '{v: 1'b1, w: 1'b1, rd: 5'd5,  pc: 32'h0000_0010, d: 32'hDEAD_BEEF, frame: 1'b1};
    vecs[1] = '{v: 1'b0, w: 1'b1, rd: 5'd3,  pc: 32'h0000_0020, d: 32'h1111_1111, frame: 1'b0};
    vecs[2] = '{v: 1'b1, w: 1'b0, rd: 5'd3,  pc: 32'h0000_0024, d: 32'h2222_2222, frame: 1'b0};
    vecs[3] = '{v: 1'b1, w: 1'b1, rd: 5'd0,  pc: 32'h0000_0028, d: 32'h3333_3333, frame: 1'b0};
    vecs[4] = '{v: 1'b1, w: 1'b1, rd: 5'd31, pc: 32'hFFFF_FFFC, d: 32'h0000_0000, frame: 1'b1};
    vecs[5] = '{v: 1'b1, w: 1'b1, rd: 5'd1,  pc: 32'h8000_0000, d: 32'h0123_4567, frame: 1'b1};

    do_reset();
    check("reset_tx", 32'(tx0), 32'd1);
    check("reset_busy", 32'(busy0), 32'd0);
    check("reset_overflow", 32'(ovf0), 32'd0);
    check("reset_drop_count", 32'(dc0), 32'd0);
    tick(3);

    // Single-record vectors on the filtering instance
    for (int i = 0; i < 6; i++) begin
      rxq.delete();
      drive(vecs[i].v, vecs[i].w, vecs[i].rd, vecs[i].pc, vecs[i].d);
      n = cyc;
      check("vec_busy_after_capture", 32'(busy0), 32'(vecs[i].frame));
      tick(n + FRAME_CYC + 1 - cyc);
      check("vec_busy_last_cycle", 32'(busy0), 32'(vecs[i].frame));
      tick(1);
      check("vec_busy_after_frame", 32'(busy0), 32'd0);
      tick(10);
      check("vec_byte_count", 32'(rxq.size()), vecs[i].frame ? 32'd10 : 32'd0);
      if (vecs[i].frame) check_frame("vec", 0, vecs[i].pc, vecs[i].rd, vecs[i].d, n + 2);
      $display("vector %0d rd=%0d pc=%h data=%h bytes=%0d", i, vecs[i].rd, vecs[i].pc,
               vecs[i].d, rxq.size());
    end

    // x0 with the filter off produces a frame with rd byte 00
    do_reset();
    mon_sel = 1'b1;
    drive(1'b1, 1'b1, 5'd0, 32'h0000_0044, 32'h55AA_00FF);
    n = cyc;
    check("x0_filtered_busy", 32'(busy0), 32'd0);
    check("x0_unfiltered_busy", 32'(busy1), 32'd1);
    tick(FRAME_CYC + 20);
    check("x0_filtered_busy_end", 32'(busy0), 32'd0);
    check("x0_byte_count", 32'(rxq.size()), 32'd10);
    check_frame("x0", 0, 32'h0000_0044, 5'd0, 32'h55AA_00FF, n + 2);
    $display("x0 unfiltered: bytes=%0d", rxq.size());
    mon_sel = 1'b0;

    // Burst of 6: one in flight, four buffered, one dropped
    do_reset();
    n = cyc + 1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 5'(i + 1), 32'h0000_1000 + 32'(4 * i), 32'hA000_0000 + 32'(i));
      if (i == 4) check("burst_overflow_before", 32'(ovf0), 32'd0);
    end
    check("burst_overflow", 32'(ovf0), 32'd1);
    check("burst_drop_count", 32'(dc0), 32'd1);
    tick(5 * FRAME_GAP + 20);
    check("burst_byte_count", 32'(rxq.size()), 32'd50);
    for (int f = 0; f < 5; f++)
      check_frame("burst", 10 * f, 32'h0000_1000 + 32'(4 * f), 5'(f + 1),
                  32'hA000_0000 + 32'(f), n + 2 + FRAME_GAP * f);
    $display("burst: bytes=%0d drops=%0d", rxq.size(), dc0);

    // Full FIFO plus a capture on the LOAD cycle: accepted, not dropped
    do_reset();
    drive(1'b1, 1'b1, 5'd10, 32'h0000_2000, 32'hC000_0000);
    n = cyc;
    tick(4);
    for (int i = 1; i < 5; i++)
      drive(1'b1, 1'b1, 5'(10 + i), 32'h0000_2000 + 32'(4 * i), 32'hC000_0000 + 32'(i));
    tick(n + FRAME_CYC + 3 - cyc);
    drive(1'b1, 1'b1, 5'd15, 32'h0000_2014, 32'hC000_0005);
    check("pop_push_drop_count", 32'(dc0), 32'd0);
    check("pop_push_overflow", 32'(ovf0), 32'd0);
    tick(6 * FRAME_GAP + 20);
    check("pop_push_byte_count", 32'(rxq.size()), 32'd60);
    for (int f = 0; f < 6; f++)
      check_frame("pop_push", 10 * f, 32'h0000_2000 + 32'(4 * f), 5'(10 + f),
                  32'hC000_0000 + 32'(f), n + 2 + FRAME_GAP * f);
    $display("push on pop: bytes=%0d drops=%0d", rxq.size(), dc0);

    // Reset during byte 3 with a second record buffered
    do_reset();
    drive(1'b1, 1'b1, 5'd7, 32'h0000_3000, 32'h1234_5678);
    n = cyc;
    drive(1'b1, 1'b1, 5'd8, 32'h0000_3004, 32'h9ABC_DEF0);
    tick(n + 2 + 30 * CPB + 10 - cyc);
    rst = 1'b1;
    tick(1);
    check("midrst_tx", 32'(tx0), 32'd1);
    check("midrst_busy", 32'(busy0), 32'd0);
    rst = 1'b0;
    tick(FRAME_CYC + 200);
    check("midrst_bytes_before_reset", 32'(rxq.size()), 32'd3);
    check("midrst_busy_after", 32'(busy0), 32'd0);
    check("midrst_tx_after", 32'(tx0), 32'd1);
    $display("reset mid-frame: bytes=%0d", rxq.size());

    // Drop counter saturation
    do_reset();
    for (int i = 1; i <= 310; i++) begin
      drive(1'b1, 1'b1, 5'd9, 32'(i), 32'(i));
      if (i == 5)   check("sat_dc_5", 32'(dc0), 32'd0);
      if (i == 6)   check("sat_dc_6", 32'(dc0), 32'd1);
      if (i == 259) check("sat_dc_259", 32'(dc0), 32'd254);
      if (i == 260) check("sat_dc_260", 32'(dc0), 32'd255);
    end
    check("sat_dc_hold", 32'(dc0), 32'd255);
    check("sat_overflow", 32'(ovf0), 32'd1);
    $display("saturation: drop_count=%0d overflow=%0d", dc0, ovf0);
    do_reset();
    check("sat_reset_dc", 32'(dc0), 32'd0);
    check("sat_reset_overflow", 32'(ovf0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
